// File: rtl/io_uart_pkg.sv
// Shared types and constants for the 64-bit UART transmit path.
package io_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int BYTES_PER_WORD = 8;
  localparam int DATA_BITS      = 8;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_uart_tx64_if.sv
// CPU store port and UART status/line signals bundled for io_uart_tx64.
interface io_uart_tx64_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int LW = io_uart_pkg::level_w(FIFO_DEPTH);

  logic          io_write;
  logic [63:0]   io_data;
  logic          tx;
  logic          busy;
  logic          full;
  logic          overflow;
  logic [LW-1:0] level;

  modport master (
    output io_write, io_data,
    input  tx, busy, full, overflow, level
  );

  modport slave (
    input  io_write, io_data,
    output tx, busy, full, overflow, level
  );
endinterface

// File: rtl/io_fifo64.sv
// Synchronous word FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module io_fifo64
  import io_uart_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/io_uart_tx64.sv
// Buffers 64-bit CPU stores and serializes each as eight back-to-back 8N1 frames, LSB byte first.
module io_uart_tx64
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           clk,
  input logic           rst,
  io_uart_tx64_if.slave bus
);

  localparam int LW = level_w(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(BYTES_PER_WORD - 1);

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [2:0]    byte_cnt, byte_n;
  logic [63:0]   shreg, shreg_n;
  logic          baud_done;
  logic          tx, tx_d;
  logic          busy, busy_d;
  logic          overflow;

  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [63:0]   head;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;

  io_fifo64 #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata (bus.io_data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // A pop on the same edge frees a slot, so a store into a full FIFO still lands.
  assign push_ok = bus.io_write && (!full || pop);
  assign drop    = bus.io_write && full && !pop;

  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_cnt;
    byte_n    = byte_cnt;
    shreg_n   = shreg;
    pop       = 1'b0;
    baud_done = (baud_cnt == BAUD_LAST);
    if (state != IDLE) baud_n = baud_done ? '0 : baud_cnt + BW'(1);

    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          byte_n  = '0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          shreg_n = shreg >> 1;
          if (bit_cnt == BIT_LAST) state_n = STOP;
          else                     bit_n   = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          if (byte_cnt != BYTE_LAST) begin
            byte_n  = byte_cnt + 3'd1;
            state_n = START;
          end else if (!empty) begin
            // Chain straight into the next word without an idle cycle.
            pop     = 1'b1;
            shreg_n = head;
            byte_n  = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_n[0];
      default: tx_d = 1'b1;
    endcase
  end

  // busy looks ahead one edge so it tracks the registered FSM state and FIFO level.
  assign busy_d = (state_n != IDLE) || push_ok || (level > LW'(1)) || (!empty && !pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      tx       <= tx_d;
      busy     <= busy_d;
      overflow <= overflow | drop;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  assign bus.tx       = tx;
  assign bus.busy     = busy;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.level    = level;

endmodule

// File: tb/tb_io_uart_tx64.sv
// Directed bench for io_uart_tx64: cycle-exact frame checks, overflow, full-with-pop and async reset.
module tb_io_uart_tx64;
  import io_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FW    = 10 * CPB;

  logic clk = 1'b0;
  logic rst;

  io_uart_tx64_if #(.FIFO_DEPTH(DEPTH)) bus ();

  io_uart_tx64 #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected line waveform of one 8N1 frame, one entry per clock.
  function automatic logic [FW-1:0] frame_bits(input logic [7:0] b);
    logic [FW-1:0] r;
    for (int k = 0; k < FW; k++) begin
      int s;
      s = k / CPB;
      if (s == 0)      r[k] = 1'b0;
      else if (s == 9) r[k] = 1'b1;
      else             r[k] = b[s-1];
    end
    return r;
  endfunction

  // Call at the negedge of the first START cycle; returns at the negedge of the last STOP cycle.
  task automatic rx_word(input string tag, input logic [63:0] w);
    logic [FW-1:0] obs;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < FW; k++) begin
        if (f != 0 || k != 0) @(negedge clk);
        obs[k] = bus.tx;
      end
      check($sformatf("%s_byte%0d", tag, f), 64'(obs), 64'(frame_bits(w[8*f +: 8])));
    end
  endtask

  // Call at a negedge; io_write is high for exactly that one cycle.
  task automatic write1(input logic [63:0] d);
    bus.io_write = 1'b1;
    bus.io_data  = d;
    @(negedge clk);
    bus.io_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ovf_words [5];
    logic [63:0] fp_words  [6];
    ovf_words = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
    fp_words  = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h55AA55AA00FF00FF,
                  64'h8000000000000001, 64'h0F0F0F0FF0F0F0F0, 64'hC3C3A5A5123400FF};

    rst          = 1'b1;
    bus.io_write = 1'b0;
    bus.io_data  = '0;
    @(negedge clk);
    check("rst_tx",       64'(bus.tx),       64'd1);
    check("rst_busy",     64'(bus.busy),     64'd0);
    check("rst_full",     64'(bus.full),     64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_level",    64'(bus.level),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word: exact latency, frame contents, busy fall at c+322
    write1(64'h0000_0000_0000_0041);
    check("single_level_c1", 64'(bus.level), 64'd1);
    check("single_busy_c1",  64'(bus.busy),  64'd1);
    check("single_tx_c1",    64'(bus.tx),    64'd1);
    @(negedge clk);
    rx_word("single", 64'h0000_0000_0000_0041);
    check("single_busy_last_stop", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("single_busy_fall", 64'(bus.busy),  64'd0);
    check("single_tx_idle",   64'(bus.tx),    64'd1);
    check("single_level_end", 64'(bus.level), 64'd0);

    // Back-to-back words: 16 contiguous frames, no idle between words
    write1(64'h0807060504030201);
    write1(64'h100F0E0D0C0B0A09);
    rx_word("b2b_w0", 64'h0807060504030201);
    @(negedge clk);
    rx_word("b2b_w1", 64'h100F0E0D0C0B0A09);
    @(negedge clk);
    check("b2b_busy_end", 64'(bus.busy), 64'd0);

    // Overflow: six writes into depth 4 while word 1 is on the line
    fork
      begin
        for (int i = 0; i < 5; i++) write1(ovf_words[i]);
        check("ovf_level_peak", 64'(bus.level),    64'd4);
        check("ovf_full",       64'(bus.full),     64'd1);
        check("ovf_flag_pre",   64'(bus.overflow), 64'd0);
        write1(64'd6);
        check("ovf_flag_set",   64'(bus.overflow), 64'd1);
        check("ovf_level_hold", 64'(bus.level),    64'd4);
      end
      begin
        repeat (2) @(negedge clk);
        rx_word("ovf_w1", ovf_words[0]);
        for (int i = 1; i < 5; i++) begin
          @(negedge clk);
          rx_word($sformatf("ovf_w%0d", i + 1), ovf_words[i]);
        end
      end
    join
    @(negedge clk);
    check("ovf_no_w6_tx",   64'(bus.tx),       64'd1);
    check("ovf_no_w6_busy", 64'(bus.busy),     64'd0);
    check("ovf_sticky_a",   64'(bus.overflow), 64'd1);

    // Sticky flag survives an accepted write and a full drain
    write1(64'h7777_0000_1234_5678);
    check("sticky_level", 64'(bus.level), 64'd1);
    @(negedge clk);
    rx_word("sticky", 64'h7777_0000_1234_5678);
    @(negedge clk);
    check("sticky_busy",  64'(bus.busy),     64'd0);
    check("sticky_flag",  64'(bus.overflow), 64'd1);
    rst = 1'b1;
    #1;
    check("sticky_cleared", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full FIFO with a write landing on the end-of-word pop edge
    fork
      begin
        for (int i = 0; i < 5; i++) write1(fp_words[i]);
        check("fp_full_pre",  64'(bus.full),  64'd1);
        check("fp_level_pre", 64'(bus.level), 64'd4);
        repeat (316) @(negedge clk);
        check("fp_full_at_pop", 64'(bus.full), 64'd1);
        write1(fp_words[5]);
        check("fp_overflow", 64'(bus.overflow), 64'd0);
        check("fp_level",    64'(bus.level),    64'd4);
      end
      begin
        repeat (2) @(negedge clk);
        rx_word("fp_w0", fp_words[0]);
        for (int i = 1; i < 6; i++) begin
          @(negedge clk);
          rx_word($sformatf("fp_w%0d", i), fp_words[i]);
        end
      end
    join
    @(negedge clk);
    check("fp_busy_end",     64'(bus.busy),     64'd0);
    check("fp_overflow_end", 64'(bus.overflow), 64'd0);

    // Async reset during DATA of byte 3 with two words queued
    for (int i = 0; i < 3; i++) write1(64'd0);
    repeat (137) @(negedge clk);
    check("mid_tx_low", 64'(bus.tx),    64'd0);
    check("mid_level",  64'(bus.level), 64'd2);
    check("mid_busy",   64'(bus.busy),  64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx",    64'(bus.tx),    64'd1);
    check("mid_rst_level", 64'(bus.level), 64'd0);
    check("mid_rst_busy",  64'(bus.busy),  64'd0);
    check("mid_rst_full",  64'(bus.full),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx",    64'(bus.tx),    64'd1);
    check("post_rst_level", 64'(bus.level), 64'd0);
    write1(64'hDEADBEEFCAFEF00D);
    @(negedge clk);
    rx_word("post_rst", 64'hDEADBEEFCAFEF00D);
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
